// File: rtl/regfile_sb_if.sv
// Register-file bus: decode read/issue ports plus write-back port.
interface regfile_sb_if #(
  parameter int WIDTH = 16,
  parameter int SELW  = 3
);
  logic [SELW-1:0]  rd1_sel;
  logic [WIDTH-1:0] rd1_data;
  logic             rd1_busy;
  logic [SELW-1:0]  rd2_sel;
  logic [WIDTH-1:0] rd2_data;
  logic             rd2_busy;
  logic             wr_en;
  logic [SELW-1:0]  wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             iss_en;
  logic [SELW-1:0]  iss_sel;
  logic             iss_full;
  logic             sb_err;

  modport slave (
    input  rd1_sel, rd2_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel,
    output rd1_data, rd1_busy, rd2_data, rd2_busy, iss_full, sb_err
  );

  modport master (
    output rd1_sel, rd2_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel,
    input  rd1_data, rd1_busy, rd2_data, rd2_busy, iss_full, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write-back port,
// optional write-to-read bypass and a per-register in-flight scoreboard.
module regfile_sb #(
  parameter int WIDTH  = 16,
  parameter int NREG   = 8,
  parameter int SELW   = 3,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  logic [WIDTH-1:0] r_regs [NREG];
  logic [1:0]       r_cnt  [NREG];
  logic             r_sb_err;

  logic [1:0]       w_cnt_nxt [NREG];
  logic             w_inc     [NREG];
  logic             w_dec     [NREG];
  logic             w_wr_ok;
  logic             w_iss_full;
  logic             w_ovf;
  logic             w_unmatched;
  logic             w_rd1_hit;
  logic             w_rd2_hit;
  logic [WIDTH-1:0] w_rd1_data;
  logic [WIDTH-1:0] w_rd2_data;
  logic             w_rd1_busy;
  logic             w_rd2_busy;

  function automatic logic f_in_range(input logic [SELW-1:0] sel);
    return (32'(sel) < NREG);
  endfunction

  // Write qualification, scoreboard error detection and issue-full status
  always_comb begin
    w_wr_ok     = bus.wr_en && f_in_range(bus.wr_sel);
    w_iss_full  = 1'b0;
    w_unmatched = 1'b0;
    if (f_in_range(bus.iss_sel))
      w_iss_full = (r_cnt[bus.iss_sel] == 2'd3);
    if (w_wr_ok)
      w_unmatched = (r_cnt[bus.wr_sel] == 2'd0);
    w_ovf = bus.iss_en && w_iss_full;
  end

  // Read ports: stored value, or forwarded write data when bypass is enabled;
  // a retiring last producer whose data is forwarded no longer counts as busy
  always_comb begin
    w_rd1_hit  = (BYPASS != 0) && w_wr_ok && (bus.wr_sel == bus.rd1_sel);
    w_rd2_hit  = (BYPASS != 0) && w_wr_ok && (bus.wr_sel == bus.rd2_sel);
    w_rd1_data = '0;
    w_rd2_data = '0;
    w_rd1_busy = 1'b0;
    w_rd2_busy = 1'b0;
    if (f_in_range(bus.rd1_sel)) begin
      w_rd1_data = w_rd1_hit ? bus.wr_data : r_regs[bus.rd1_sel];
      w_rd1_busy = (r_cnt[bus.rd1_sel] != 2'd0) &&
                   !(w_rd1_hit && (r_cnt[bus.rd1_sel] == 2'd1));
    end
    if (f_in_range(bus.rd2_sel)) begin
      w_rd2_data = w_rd2_hit ? bus.wr_data : r_regs[bus.rd2_sel];
      w_rd2_busy = (r_cnt[bus.rd2_sel] != 2'd0) &&
                   !(w_rd2_hit && (r_cnt[bus.rd2_sel] == 2'd1));
    end
  end

  // Per-register saturating in-flight counter next state
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      w_inc[i]     = bus.iss_en && (bus.iss_sel == SELW'(i)) && (r_cnt[i] != 2'd3);
      w_dec[i]     = bus.wr_en  && (bus.wr_sel  == SELW'(i)) && (r_cnt[i] != 2'd0);
      w_cnt_nxt[i] = r_cnt[i];
      if (w_inc[i] && !w_dec[i])
        w_cnt_nxt[i] = r_cnt[i] + 2'd1;
      else if (w_dec[i] && !w_inc[i])
        w_cnt_nxt[i] = r_cnt[i] - 2'd1;
    end
  end

  // Register storage, scoreboard counters and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_sb_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        if (w_wr_ok && (bus.wr_sel == SELW'(i)))
          r_regs[i] <= bus.wr_data;
      end
      if (w_ovf || w_unmatched)
        r_sb_err <= 1'b1;
    end
  end

  assign bus.rd1_data = w_rd1_data;
  assign bus.rd2_data = w_rd2_data;
  assign bus.rd1_busy = w_rd1_busy;
  assign bus.rd2_busy = w_rd2_busy;
  assign bus.iss_full = w_iss_full;
  assign bus.sb_err   = r_sb_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: one bypassing instance and one non-bypassing instance
// receive identical stimulus; outputs are checked against hand-derived values.
module tb_regfile_sb;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_sb_if #(.WIDTH(16), .SELW(3)) bus1 ();
  regfile_sb_if #(.WIDTH(16), .SELW(3)) bus0 ();

  regfile_sb #(.WIDTH(16), .NREG(8), .SELW(3), .BYPASS(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  regfile_sb #(.WIDTH(16), .NREG(8), .SELW(3), .BYPASS(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  assign bus0.rd1_sel = bus1.rd1_sel;
  assign bus0.rd2_sel = bus1.rd2_sel;
  assign bus0.wr_en   = bus1.wr_en;
  assign bus0.wr_sel  = bus1.wr_sel;
  assign bus0.wr_data = bus1.wr_data;
  assign bus0.iss_en  = bus1.iss_en;
  assign bus0.iss_sel = bus1.iss_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus1.wr_en  = 1'b0;
    bus1.iss_en = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst          = 1'b0;
    bus1.rd1_sel = '0;
    bus1.rd2_sel = '0;
    bus1.wr_en   = 1'b0;
    bus1.wr_sel  = '0;
    bus1.wr_data = '0;
    bus1.iss_en  = 1'b0;
    bus1.iss_sel = '0;

    // Reset state
    #2;
    chk("rst_rd1_data", bus1.rd1_data, 32'h0);
    chk("rst_rd1_busy", bus1.rd1_busy, 32'h0);
    chk("rst_iss_full", bus1.iss_full, 32'h0);
    chk("rst_sb_err",   bus1.sb_err,   32'h0);
    step();
    rst = 1'b1;
    step();

    // Test 1: write r3, then asynchronous reset between edges
    bus1.wr_en = 1'b1; bus1.wr_sel = 3'd3; bus1.wr_data = 16'hBEEF;
    step();
    idle();
    bus1.rd1_sel = 3'd3;
    #1;
    chk("t1_pre_data", bus1.rd1_data, 32'hBEEF);
    chk("t1_pre_err",  bus1.sb_err,   32'h1);
    rst = 1'b0;
    #1;
    chk("t1_rst_data", bus1.rd1_data, 32'h0);
    chk("t1_rst_busy", bus1.rd1_busy, 32'h0);
    chk("t1_rst_err",  bus1.sb_err,   32'h0);
    chk("t1_rst_err0", bus0.sb_err,   32'h0);
    rst = 1'b1;
    step();

    // Test 2: same-cycle bypass vs. no bypass
    bus1.wr_en = 1'b1; bus1.wr_sel = 3'd5; bus1.wr_data = 16'h1234;
    bus1.rd1_sel = 3'd5; bus1.rd2_sel = 3'd5;
    #1;
    chk("t2_byp_rd1",   bus1.rd1_data, 32'h1234);
    chk("t2_byp_rd2",   bus1.rd2_data, 32'h1234);
    chk("t2_nobyp_rd1", bus0.rd1_data, 32'h0);
    chk("t2_nobyp_rd2", bus0.rd2_data, 32'h0);
    step();
    idle();
    #1;
    chk("t2_nobyp_next", bus0.rd1_data, 32'h1234);
    chk("t2_byp_next",   bus1.rd2_data, 32'h1234);
    pulse_reset();

    // Test 3: RAW stall and last-producer retire
    bus1.iss_en = 1'b1; bus1.iss_sel = 3'd2;
    step();
    idle();
    bus1.rd1_sel = 3'd2;
    #1;
    chk("t3_busy",  bus1.rd1_busy, 32'h1);
    chk("t3_busy0", bus0.rd1_busy, 32'h1);
    bus1.wr_en = 1'b1; bus1.wr_sel = 3'd2; bus1.wr_data = 16'h00AA;
    #1;
    chk("t3_wb_busy",  bus1.rd1_busy, 32'h0);
    chk("t3_wb_data",  bus1.rd1_data, 32'h00AA);
    chk("t3_wb_busy0", bus0.rd1_busy, 32'h1);
    chk("t3_wb_data0", bus0.rd1_data, 32'h0);
    step();
    idle();
    #1;
    chk("t3_after_busy0", bus0.rd1_busy, 32'h0);
    chk("t3_after_data0", bus0.rd1_data, 32'h00AA);
    chk("t3_err",         bus1.sb_err,   32'h0);

    // Test 4: saturation at three in-flight writers
    bus1.rd2_sel = 3'd7;
    bus1.iss_en = 1'b1; bus1.iss_sel = 3'd7;
    #1;
    chk("t4_full_0", bus1.iss_full, 32'h0);
    step();
    step();
    #1;
    chk("t4_full_2", bus1.iss_full, 32'h0);
    step();
    idle();
    #1;
    chk("t4_full_3", bus1.iss_full, 32'h1);
    chk("t4_busy_3", bus1.rd2_busy, 32'h1);
    chk("t4_err_3",  bus1.sb_err,   32'h0);
    bus1.iss_en = 1'b1;
    step();
    idle();
    #1;
    chk("t4_ovf_err",  bus1.sb_err,   32'h1);
    chk("t4_ovf_full", bus1.iss_full, 32'h1);
    bus1.wr_en = 1'b1; bus1.wr_sel = 3'd7; bus1.wr_data = 16'h0001;
    step();
    bus1.wr_data = 16'h0002;
    step();
    bus1.wr_data = 16'h0003;
    #1;
    chk("t4_last_busy",  bus1.rd2_busy, 32'h0);
    chk("t4_last_busy0", bus0.rd2_busy, 32'h1);
    step();
    idle();
    #1;
    chk("t4_end_busy",  bus1.rd2_busy, 32'h0);
    chk("t4_end_busy0", bus0.rd2_busy, 32'h0);
    chk("t4_end_full",  bus1.iss_full, 32'h0);
    chk("t4_end_data",  bus1.rd2_data, 32'h0003);
    chk("t4_end_err",   bus1.sb_err,   32'h1);
    pulse_reset();

    // Test 5: simultaneous issue and write-back on the same register
    bus1.iss_en = 1'b1; bus1.iss_sel = 3'd4;
    step();
    bus1.wr_en = 1'b1; bus1.wr_sel = 3'd4; bus1.wr_data = 16'h4444;
    step();
    idle();
    bus1.rd1_sel = 3'd4;
    #1;
    chk("t5_busy", bus1.rd1_busy, 32'h1);
    chk("t5_data", bus1.rd1_data, 32'h4444);
    chk("t5_err",  bus1.sb_err,   32'h0);
    bus1.wr_en = 1'b1; bus1.wr_sel = 3'd4; bus1.wr_data = 16'h4545;
    step();
    idle();
    #1;
    chk("t5_retire_busy", bus1.rd1_busy, 32'h0);
    chk("t5_retire_err",  bus1.sb_err,   32'h0);

    // Test 6: unmatched write-back
    bus1.wr_en = 1'b1; bus1.wr_sel = 3'd1; bus1.wr_data = 16'h5555;
    step();
    idle();
    bus1.rd1_sel = 3'd1;
    #1;
    chk("t6_data",  bus1.rd1_data, 32'h5555);
    chk("t6_busy",  bus1.rd1_busy, 32'h0);
    chk("t6_err",   bus1.sb_err,   32'h1);
    chk("t6_err0",  bus0.sb_err,   32'h1);
    bus1.iss_sel = 3'd1;
    #1;
    chk("t6_full",  bus1.iss_full, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
